// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

   // Loader FSM states; CSUM is only reachable when the checksum option is built.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      DATA = 3'd2,
      CSUM = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_e;

   localparam int BYTES_PER_WORD = 4;
   localparam int HDR_W          = 8;
   localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

   // A header is usable when it names at least one word and no more than the memory holds.
   function automatic logic hdr_ok(input logic [HDR_W-1:0] n, input int depth);
      return (n != '0) && (int'(n) <= depth);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in, instruction-memory write port and status out.
// master = the loader, slave = whoever feeds the stream and owns the memory.
interface imem_loader_if #(
   parameter int ADDR_W = 5
);
   logic              start;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst_n;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      input  start, byte_in, byte_valid,
      output byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, done, err
   );

   modport slave (
      output start, byte_in, byte_valid,
      input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, done, err
   );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: big-endian byte-to-word packer. The first three bytes
// of a word are held in a partial register; the fourth completes the word
// combinationally so the parent can register it on the same edge.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr_i,
   input  logic                        en_i,
   input  logic [7:0]                  byte_i,
   output logic                        word_valid_o,
   output logic [8*BYTES_PER_WORD-1:0] word_o
);
   localparam int PART_W = 8 * (BYTES_PER_WORD - 1);
   localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

   logic [PART_W-1:0]     part_q, part_d;
   logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

   assign word_o       = {part_q, byte_i};
   assign word_valid_o = en_i && (cnt_q == LAST_BYTE);

   // Shift in accepted bytes; partial contents persist across stream gaps.
   always_comb begin
      part_d = part_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         part_d = '0;
         cnt_d  = '0;
      end else if (en_i) begin
         part_d = word_o[PART_W-1:0];
         cnt_d  = cnt_q + 1'b1;
      end
   end

   // Partial-word and byte-count registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         part_q <= '0;
         cnt_q  <= '0;
      end else begin
         part_q <= part_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a framed byte stream (count byte + 4N data bytes) into
// instruction memory and holds the CPU in reset until the image is complete.
// Build option IMEM_LOADER_CHECKSUM_EN: a trailing XOR-of-data byte must match
// before the CPU is released.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic          clk,
   input  logic          rst,
   imem_loader_if.master bus
);
   localparam logic [2:0] S_IDLE = IDLE;
   localparam logic [2:0] S_HDR  = HDR;
   localparam logic [2:0] S_DATA = DATA;
   localparam logic [2:0] S_CSUM = CSUM;
   localparam logic [2:0] S_DONE = DONE;
   localparam logic [2:0] S_ERR  = ERR;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] last_idx_q, last_idx_d;
   logic [ADDR_W-1:0] word_idx_q, word_idx_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              cpu_rst_n_q, cpu_rst_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   logic        accept;
   logic        restart;
   logic        pk_clr;
   logic        pk_en;
   logic        word_valid;
   logic [31:0] word;

   assign bus.byte_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign accept         = bus.byte_valid && bus.byte_ready;
   assign restart        = bus.start &&
                           ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
   assign pk_clr         = restart || ((state_q == S_HDR) && accept);
   assign pk_en          = accept && (state_q == S_DATA);

   imem_loader_byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (pk_clr),
      .en_i         (pk_en),
      .byte_i       (bus.byte_in),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.cpu_rst_n  = cpu_rst_n_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;

   // Next-state logic: header check, word writes, completion and restart.
   always_comb begin
      state_d     = state_q;
      last_idx_d  = last_idx_q;
      word_idx_d  = word_idx_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rst_n_d = cpu_rst_n_q;
      busy_d      = busy_q;
      done_d      = done_q;
      err_d       = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      case (state_q)
         S_HDR: begin
            if (accept) begin
               if (!hdr_ok(bus.byte_in, DEPTH)) begin
                  state_d = S_ERR;
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
               end else begin
                  state_d    = S_DATA;
                  last_idx_d = ADDR_W'(bus.byte_in - 8'd1);
                  word_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_d     = '0;
`endif
               end
            end
         end
         S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept) begin
               csum_d = csum_q ^ bus.byte_in;
            end
`endif
            if (word_valid) begin
               we_d    = 1'b1;
               addr_d  = word_idx_q;
               wdata_d = word;
               if (word_idx_q == last_idx_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
`endif
               end else begin
                  word_idx_d = word_idx_q + 1'b1;
               end
            end
         end
         S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept) begin
               busy_d = 1'b0;
               if (bus.byte_in == csum_q) begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  cpu_rst_n_d = 1'b1;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
`else
            state_d = S_ERR;
            busy_d  = 1'b0;
            err_d   = 1'b1;
`endif
         end
         S_DONE: begin
            // Release lags the final write by one cycle so the last word lands first.
            cpu_rst_n_d = 1'b1;
         end
         S_ERR: begin
            cpu_rst_n_d = 1'b0;
         end
         default: begin
         end
      endcase
      // A start from any idle-like state begins a fresh load and re-asserts CPU reset.
      if (restart) begin
         state_d     = S_HDR;
         busy_d      = 1'b1;
         done_d      = 1'b0;
         err_d       = 1'b0;
         cpu_rst_n_d = 1'b0;
      end
   end

   // State and registered outputs; reset holds the CPU in reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         last_idx_q  <= '0;
         word_idx_q  <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rst_n_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         last_idx_q  <= last_idx_d;
         word_idx_q  <= word_idx_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized image loads checked against a
// stream-level model of the expected memory contents and final status.
`timescale 1ns/1ps
module tb_imem_loader;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;

   typedef logic [7:0] bq_t [$];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int wr_total = 0;
   logic [31:0] mem_dut [DEPTH] = '{default: 32'h0};
   logic [31:0] exp_mem [DEPTH] = '{default: 32'h0};

   // The instruction memory the loader writes into.
   always @(posedge clk) begin
      if (bus.imem_we === 1'b1) begin
         mem_dut[bus.imem_addr] <= bus.imem_wdata;
         wr_total <= wr_total + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Stream-level reference: header rules, big-endian packing, optional XOR check.
   function automatic void model(input bq_t s, output logic ok, output int nw);
      int n;
      logic [7:0] x;
      n  = int'(s[0]);
      ok = 1'b0;
      nw = 0;
      if (n == 0 || n > DEPTH) return;
      for (int w = 0; w < n; w++)
         exp_mem[w] = {s[1+4*w], s[2+4*w], s[3+4*w], s[4+4*w]};
      nw = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
      x = 8'h00;
      for (int i = 1; i <= 4*n; i++) x ^= s[i];
      ok = (s[4*n+1] == x);
`else
      x  = 8'h00;
      ok = 1'b1;
`endif
   endfunction

   function automatic logic [7:0] csum_of(input bq_t s);
      logic [7:0] x = 8'h00;
      for (int i = 1; i < s.size(); i++) x ^= s[i];
      return x;
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      n = 0;
      while (bus.byte_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", (n < 20), 1'b1);
      @(posedge clk);
      #1 bus.byte_valid = 1'b0;
   endtask

   task automatic run_bytes(input bq_t s, input int maxgap, input bit rnd);
      for (int i = 0; i < s.size(); i++)
         send_byte(s[i], rnd ? int'($urandom_range(0, maxgap)) : maxgap);
   endtask

   task automatic check_result(input string tag, input logic ok, input int nw, input int base);
      int mism;
      repeat (3) @(negedge clk);
      chk({tag, "_done"}, bus.done, ok);
      chk({tag, "_err"}, bus.err, !ok);
      chk({tag, "_cpu_rst_n"}, bus.cpu_rst_n, ok);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      chk({tag, "_ready"}, bus.byte_ready, 1'b0);
      chk({tag, "_writes"}, wr_total - base, nw);
      mism = 0;
      for (int i = 0; i < DEPTH; i++)
         if (mem_dut[i] !== exp_mem[i]) mism++;
      chk({tag, "_mem"}, mism, 0);
      $display("load %s: words=%0d ok=%0b done=%0b err=%0b", tag, nw, ok, bus.done, bus.err);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t  s;
      logic ok;
      int   nw, base;
      logic [7:0] hdrs [2];

      bus.start = 1'b0;
      bus.byte_in = 8'h00;
      bus.byte_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ready", bus.byte_ready, 1'b0);
      chk("rst_we", bus.imem_we, 1'b0);
      chk("rst_addr", bus.imem_addr, 0);
      chk("rst_wdata", bus.imem_wdata, 0);
      chk("rst_cpu_rst_n", bus.cpu_rst_n, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_cpu_rst_n", bus.cpu_rst_n, 1'b0);

      // Basic load with exact end-of-load timing.
      s = '{8'h02, 8'h20, 8'h0a, 8'h00, 8'h05, 8'h20, 8'h0b, 8'h00, 8'h07};
`ifdef IMEM_LOADER_CHECKSUM_EN
      s.push_back(csum_of(s));
`endif
      model(s, ok, nw);
      base = wr_total;
      pulse_start();
      chk("start_busy", bus.busy, 1'b1);
      chk("start_cpu_rst_n", bus.cpu_rst_n, 1'b0);
      run_bytes(s, 0, 1'b0);
      @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("csum_rel_cpu_rst_n", bus.cpu_rst_n, 1'b1);
      chk("csum_rel_done", bus.done, 1'b1);
      chk("csum_rel_we", bus.imem_we, 1'b0);
`else
      chk("last_we", bus.imem_we, 1'b1);
      chk("last_addr", bus.imem_addr, 1);
      chk("last_wdata", bus.imem_wdata, 32'h200b0007);
      chk("last_cpu_rst_n", bus.cpu_rst_n, 1'b0);
      @(negedge clk);
      chk("rel_we", bus.imem_we, 1'b0);
      chk("rel_cpu_rst_n", bus.cpu_rst_n, 1'b1);
      chk("rel_done", bus.done, 1'b1);
      chk("hold_addr", bus.imem_addr, 1);
      chk("hold_wdata", bus.imem_wdata, 32'h200b0007);
`endif
      check_result("basic", ok, nw, base);
      chk("basic_w0", mem_dut[0], 32'h200a0005);
      chk("basic_w1", mem_dut[1], 32'h200b0007);

      // Restart from DONE, then the same image under heavy backpressure.
      model(s, ok, nw);
      base = wr_total;
      pulse_start();
      chk("restart_done", bus.done, 1'b0);
      chk("restart_cpu_rst_n", bus.cpu_rst_n, 1'b0);
      chk("restart_busy", bus.busy, 1'b1);
      run_bytes(s, 3, 1'b0);
      check_result("backpressure", ok, nw, base);

      // Bad headers: zero words and more words than the memory holds.
      hdrs[0] = 8'h00;
      hdrs[1] = 8'h21;
      for (int h = 0; h < 2; h++) begin
         s = '{hdrs[h]};
         model(s, ok, nw);
         base = wr_total;
         pulse_start();
         run_bytes(s, 0, 1'b0);
         check_result("bad_header", ok, nw, base);
      end

      // Reset after 5 data bytes: first word stays, everything else clears at once.
      s = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      base = wr_total;
      pulse_start();
      run_bytes(s, 0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("midrst_ready", bus.byte_ready, 1'b0);
      chk("midrst_we", bus.imem_we, 1'b0);
      chk("midrst_addr", bus.imem_addr, 0);
      chk("midrst_wdata", bus.imem_wdata, 0);
      chk("midrst_cpu_rst_n", bus.cpu_rst_n, 1'b0);
      chk("midrst_busy", bus.busy, 1'b0);
      chk("midrst_done", bus.done, 1'b0);
      chk("midrst_err", bus.err, 1'b0);
      exp_mem[0] = 32'h11223344;
      chk("midrst_w0", mem_dut[0], 32'h11223344);
      chk("midrst_writes", wr_total - base, 1);
      // Start asserted while reset is held must be ignored.
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_start_busy", bus.busy, 1'b0);
      chk("rst_start_ready", bus.byte_ready, 1'b0);

      s = '{8'h01, 8'hde, 8'had, 8'hbe, 8'hef};
`ifdef IMEM_LOADER_CHECKSUM_EN
      s.push_back(csum_of(s));
`endif
      model(s, ok, nw);
      base = wr_total;
      pulse_start();
      run_bytes(s, 1, 1'b0);
      check_result("after_reset", ok, nw, base);
      chk("after_reset_w0", mem_dut[0], 32'hdeadbeef);

`ifdef IMEM_LOADER_CHECKSUM_EN
      s = '{8'h01, 8'h20, 8'h0a, 8'h00, 8'h05, 8'h2f};
      model(s, ok, nw);
      base = wr_total;
      pulse_start();
      run_bytes(s, 0, 1'b0);
      check_result("csum_good", ok, nw, base);
      chk("csum_good_done", bus.done, 1'b1);
      s = '{8'h01, 8'h20, 8'h0a, 8'h00, 8'h05, 8'h00};
      model(s, ok, nw);
      base = wr_total;
      pulse_start();
      run_bytes(s, 0, 1'b0);
      check_result("csum_bad", ok, nw, base);
      chk("csum_bad_err", bus.err, 1'b1);
`endif

      // Random images, random gaps, occasional bad headers and corrupt checksums.
      for (int it = 0; it < 16; it++) begin
         int n;
         if ($urandom_range(0, 7) == 0) begin
            s = '{($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(DEPTH + 1, 255))};
         end else begin
            n = $urandom_range(1, DEPTH);
            s = '{8'(n)};
            for (int i = 0; i < 4*n; i++) s.push_back(8'($urandom_range(0, 255)));
`ifdef IMEM_LOADER_CHECKSUM_EN
            if ($urandom_range(0, 3) == 0)
               s.push_back(csum_of(s) ^ 8'($urandom_range(1, 255)));
            else
               s.push_back(csum_of(s));
`endif
         end
         model(s, ok, nw);
         base = wr_total;
         pulse_start();
         run_bytes(s, 3, 1'b1);
         check_result("random", ok, nw, base);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
